// File: rtl/ks_sum_pipe.sv
// Final stage of the 24-bit Kogge-Stone adder: turns the last prefix-stage bundle into
// sum/carry/flags and buffers results in a 2-entry skid FIFO with valid/ready on both sides.
module ks_sum_pipe #(
  parameter int W     = 24,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_c0,
  input  logic [W-1:0]     i_gk,
  input  logic [W-1:0]     i_p_save,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W-1:0]     o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int E = W + 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t             state_reg, state_next;
  logic             wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [E-1:0]     mem_reg [2];
  logic [W-1:0]     sum_in;
  logic [E-1:0]     entry_in;
  logic [E-1:0]     head;
  logic             push, pop;

  // Each sum bit combines its own propagate with the carry into that bit.
  assign sum_in[0] = i_p_save[0] ^ i_c0;
  generate
    for (genvar gi = 1; gi < W; gi++) begin : g_sum
      assign sum_in[gi] = i_p_save[gi] ^ i_gk[gi-1];
    end
  endgenerate

  assign entry_in = {sum_in, i_gk[W-1], i_gk[W-2] ^ i_gk[W-1], ~|sum_in};

  // Handshake flags depend only on registered occupancy, so i_ready never reaches o_ready.
  always_comb begin
    state_next = state_reg;
    o_ready    = (state_reg != FULL);
    o_valid    = (state_reg != EMPTY);
    push       = i_valid & o_ready;
    pop        = o_valid & i_ready;
    case (state_reg)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= EMPTY;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
        cnt_reg    <= cnt_reg + CNT_W'(1);
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Storage only loads on a push, so garbage on idle inputs never lands here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
    end else if (push) begin
      mem_reg[wr_ptr_reg] <= entry_in;
    end
  end

  assign head   = mem_reg[rd_ptr_reg];
  assign o_sum  = head[E-1:3];
  assign o_cout = head[2];
  assign o_ovf  = head[1];
  assign o_zero = head[0];
  assign o_cnt  = cnt_reg;

endmodule
